// File: rtl/param_counter_with_features_if.sv
// param_counter_with_features_if: control inputs and count/display outputs of the board counter
interface param_counter_with_features_if #(
  parameter int WIDTH = 8,
  parameter int NDIG = (WIDTH + 3) / 4
);
  logic enable;
  logic clear;
  logic load;
  logic [WIDTH-1:0] loadData;
  logic upDown;
  logic [1:0] clkSel;
  logic satMode;
  logic [WIDTH-1:0] counter;
  logic tick;
  logic terminal;
  logic [8*NDIG-1:0] toDisp;
  modport master (
    output enable, clear, load, loadData, upDown, clkSel, satMode,
    input counter, tick, terminal, toDisp
  );
  modport slave (
    input enable, clear, load, loadData, upDown, clkSel, satMode,
    output counter, tick, terminal, toDisp
  );
endinterface

// File: rtl/param_counter_with_features.sv
// param_counter_with_features: prescaled up/down modulus counter with wrap/saturate,
// terminal-count pulse and per-nibble seven-segment outputs
module param_counter_with_features #(
  parameter int WIDTH = 8,
  parameter int MODULUS = 256,
  parameter int DIV0 = 1,
  parameter int DIV1 = 25_000_000,
  parameter int DIV2 = 50_000_000,
  parameter int DIV3 = 100_000_000,
  parameter int PRE_W = 27
) (
  input logic clk,
  input logic reset,
  param_counter_with_features_if.slave bus
);
  localparam int NDIG = (WIDTH + 3) / 4;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);
  logic [PRE_W-1:0] preCnt, divM1;
  logic [1:0] clkSelQ;
  logic [WIDTH-1:0] cnt, stepVal, cntNext;
  logic atTop, atBot, tick, bound, restart, term;
  always_comb begin
    divM1 = bus.clkSel == 2'd0 ? PRE_W'(DIV0 - 1) :
            bus.clkSel == 2'd1 ? PRE_W'(DIV1 - 1) :
            bus.clkSel == 2'd2 ? PRE_W'(DIV2 - 1) : PRE_W'(DIV3 - 1);
    tick = bus.enable && preCnt == divM1;
    atTop = cnt == MAXV;
    atBot = cnt == '0;
    bound = tick && (bus.upDown ? atBot : atTop);
    stepVal = bus.upDown ? (atBot ? (bus.satMode ? cnt : MAXV) : cnt - 1'b1)
                         : (atTop ? (bus.satMode ? cnt : '0) : cnt + 1'b1);
    cntNext = bus.clear ? '0 :
              bus.load ? (bus.loadData > MAXV ? MAXV : bus.loadData) :
              tick ? stepVal : cnt;
    // a rate change restarts the prescaler so the new interval is measured in full
    restart = bus.clear || bus.load || bus.clkSel != clkSelQ;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preCnt <= '0;
      cnt <= '0;
      term <= 1'b0;
      clkSelQ <= bus.clkSel;
    end else begin
      preCnt <= (restart || tick) ? '0 : bus.enable ? preCnt + 1'b1 : preCnt;
      cnt <= cntNext;
      term <= bound && !bus.clear && !bus.load;
      clkSelQ <= bus.clkSel;
    end
  end
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction
  logic [4*NDIG-1:0] padded;
  assign padded = (4*NDIG)'(cnt);
  for (genvar k = 0; k < NDIG; k++) begin : gDig
    assign bus.toDisp[8*k +: 8] = seg7(padded[4*k +: 4]);
  end
  assign bus.counter = cnt;
  assign bus.tick = tick;
  assign bus.terminal = term;
endmodule

// File: tb/tb_param_counter_with_features.sv
// tb_param_counter_with_features: directed vector table plus async-reset sequence
module tb_param_counter_with_features;
  typedef struct {
    logic en, clr, ld;
    logic [3:0] ldData;
    logic ud;
    logic [1:0] cs;
    logic sat;
    logic [3:0] expCnt;
    logic expTick, expTerm;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] segTab [16];
  vec_t vecs[$];
  param_counter_with_features_if #(.WIDTH(4)) bus ();
  param_counter_with_features #(
    .WIDTH(4), .MODULUS(10), .DIV0(1), .DIV1(2), .DIV2(3), .DIV3(4), .PRE_W(3)
  ) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input logic en, clr, ld, input logic [3:0] d, input logic ud,
                              input logic [1:0] cs, input logic sat, input logic [3:0] c,
                              input logic t, input logic tm);
    vec_t v;
    v.en = en; v.clr = clr; v.ld = ld; v.ldData = d; v.ud = ud; v.cs = cs; v.sat = sat;
    v.expCnt = c; v.expTick = t; v.expTerm = tm;
    vecs.push_back(v);
  endfunction
  initial begin
    segTab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    // wrap-up count at full rate
    for (int i = 1; i <= 10; i++) add(1, 0, 0, 0, 0, 0, 0, 4'(i % 10), 1, i == 10);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    // divide-by-4, then switch to divide-by-2 mid-interval
    add(1, 1, 0, 0, 0, 3, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 3, 0, 4'(r), 0, 0);
      add(1, 0, 0, 0, 0, 3, 0, 4'(r + 1), 1, 0);
    end
    add(1, 0, 0, 0, 0, 3, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 3, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 2, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 3, 1, 0);
    // clamped load then wrap-down
    add(1, 0, 1, 4'hB, 1, 0, 0, 9, 1, 0);
    for (int i = 8; i >= 0; i--) add(1, 0, 0, 0, 1, 0, 0, 4'(i), 1, 0);
    add(1, 0, 0, 0, 1, 0, 0, 9, 1, 1);
    add(1, 0, 0, 0, 1, 0, 0, 8, 1, 0);
    // saturate at top
    add(1, 0, 1, 9, 0, 0, 1, 9, 1, 0);
    add(1, 0, 0, 0, 0, 0, 1, 9, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1, 9, 1, 1);
    add(1, 0, 0, 0, 1, 0, 1, 8, 1, 0);
    // clear beats load; load works while disabled
    add(1, 1, 1, 5, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 7, 0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    add(1, 0, 1, 6, 0, 0, 0, 6, 1, 0);
    bus.enable = 0; bus.clear = 0; bus.load = 0; bus.loadData = 0;
    bus.upDown = 0; bus.clkSel = 0; bus.satMode = 0;
    #2 reset = 1;
    #1;
    chk("reset cnt", 8'(bus.counter), 8'h0);
    chk("reset term", 8'(bus.terminal), 8'h0);
    chk("reset disp", bus.toDisp, 8'hC0);
    repeat (2) @(negedge clk);
    reset = 0;
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.enable = vecs[i].en; bus.clear = vecs[i].clr; bus.load = vecs[i].ld;
      bus.loadData = vecs[i].ldData; bus.upDown = vecs[i].ud;
      bus.clkSel = vecs[i].cs; bus.satMode = vecs[i].sat;
      #1 chk($sformatf("v%0d tick", i), 8'(bus.tick), 8'(vecs[i].expTick));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cnt", i), 8'(bus.counter), 8'(vecs[i].expCnt));
      chk($sformatf("v%0d term", i), 8'(bus.terminal), 8'(vecs[i].expTerm));
      chk($sformatf("v%0d disp", i), bus.toDisp, segTab[vecs[i].expCnt]);
    end
    // async reset between edges at counter=6, then divide-by-3 restart
    @(negedge clk);
    bus.load = 0; bus.enable = 1; bus.clkSel = 2;
    #2 reset = 1;
    #1;
    chk("async cnt", 8'(bus.counter), 8'h0);
    chk("async term", 8'(bus.terminal), 8'h0);
    chk("async disp", bus.toDisp, 8'hC0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("post tick%0d", i), 8'(bus.tick), 8'(i == 3));
      @(posedge clk);
      #1 chk($sformatf("post cnt%0d", i), 8'(bus.counter), 8'(i == 3));
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_counter_with_features.md
# param_counter_with_features

Parametrised up/down counter with a selectable prescaler, synchronous load and clear, wrap or saturate modes at a programmable modulus, a terminal-count pulse, and per-nibble seven-segment outputs. It is the generalised successor to the team's 4-bit board counter and sits between the board buttons/switches and the seven-segment display bank. It runs on the single board clock; the rate selection makes the count visible without a divided clock net.

## Interface
- WIDTH, 8: counter width in bits.
- MODULUS, 256: count range 0..MODULUS-1; 2 ≤ MODULUS ≤ 2^WIDTH.
- DIV0, 1: prescaler divisor when clkSel=0 (1 = count every cycle).
- DIV1, 25_000_000: divisor when clkSel=1.
- DIV2, 50_000_000: divisor when clkSel=2.
- DIV3, 100_000_000: divisor when clkSel=3.
- PRE_W, 27: prescaler register width; must hold max(DIVn)-1.
- NDIG, derived ceil(WIDTH/4): number of display digits.

Ports:
- clk  in  1  board clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  1 = counting allowed; 0 = freeze counter and prescaler.
- clear  in  1  synchronous clear to 0, highest functional priority.
- load  in  1  synchronous load of loadData.
- loadData  in  WIDTH  value to load.
- upDown  in  1  0 = count up, 1 = count down.
- clkSel  in  2  selects DIV0..DIV3.
- satMode  in  1  0 = wrap at bounds, 1 = saturate at bounds.
- counter  out  WIDTH  registered count value.
- tick  out  1  combinational, high in cycles where the prescaler expires and enable=1.
- terminal  out  1  registered one-cycle pulse on a bound event.
- toDisp  out  8*NDIG  seven-segment patterns; digit k from counter[4k+3:4k] (upper nibble zero-padded), same encoding as the team's hex seven-segment decoder.

## Operation
- Prescaler pre_cnt: with enable=1, increments each cycle; when pre_cnt == DIVsel-1, tick=1 and pre_cnt returns to 0 on the next edge. With enable=0: pre_cnt holds, tick=0.
- pre_cnt is forced to 0 on any edge where clear=1, load=1, or clkSel differs from its registered value of the previous cycle.
- Counter priority per edge: clear → 0; else load → loadData, clamped to MODULUS-1 if larger; else if tick: count step; else hold.
- clear and load act regardless of enable and tick.
- Up step: counter+1; at MODULUS-1 → 0 (wrap) or hold at MODULUS-1 (saturate).
- Down step: counter-1; at 0 → MODULUS-1 (wrap) or hold at 0 (saturate).
- terminal is set on the edge after a tick that wraps or attempts to pass a bound (a saturate attempt counts too). It is cleared on every other edge. It is 0 after clear or load.
- upDown, satMode and clkSel may change at any time and take effect for the next tick.
- Arithmetic is in WIDTH bits. The modulus compare is done on the full value; there is no overflow into unused codes.

## Timing
- Reset (async assert): counter=0, pre_cnt=0, terminal=0, the registered clkSel copy is set to the current clkSel, and toDisp shows all-zero digits.
- Operation resumes on the first rising edge after reset deasserts. The first tick comes DIVsel cycles later.
- With DIVsel=N and enable held high, the counter changes once every N cycles. tick is high in the cycle before each change.
- Load/clear latency: 1 cycle; counter shows the new value after the edge. The next count step follows N cycles later.
- toDisp is combinational from counter, so it has zero additional latency.
- Reset asserted mid-count overrides everything immediately, including a pending terminal.

## Test plan
Parameters for the bench: WIDTH=4, MODULUS=10, DIV0=1, DIV1=2, DIV2=3, DIV3=4.
- Reset, enable=1, clkSel=0, upDown=0, satMode=0 → counter 0,1,…,9,0 on consecutive edges; terminal high exactly in the cycle after 9→0.
- clkSel=3, count up from 0 → counter changes every 4 cycles. Switch clkSel to 1 mid-interval → prescaler restarts, and the next change comes 2 cycles later.
- load=1, loadData=4'hB, upDown=1, satMode=0 → counter=9 (clamped). Then it counts 8,…,0,9; terminal pulses after 0→9.
- satMode=1, counter=9, up → stays 9 and terminal pulses on each tick. Set upDown=1 → 8 on the next tick.
- clear and load both high with loadData=5 → counter=0. With enable=0 and load=1, loadData=7 → counter=7, then holds with tick=0.
- Assert reset asynchronously between edges at counter=6 → counter=0 and terminal=0 immediately. After release, the first increment comes DIVsel cycles later.
